// File: rtl/sm_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package sm_bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [63:0] bcd_max(input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r * 64'd10 + 64'd9;
    return r;
  endfunction

endpackage

// File: rtl/sm_bin_to_bcd_8_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface sm_bin_to_bcd_8_if
  import sm_bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                            start;
  logic [WIDTH-1:0]                bin;
  logic                            busy;
  logic                            done;
  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd;
  logic                            overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/sm_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module sm_bcd_digit_adj
  import sm_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/sm_bin_to_bcd_8.sv
// Sequential double-dabble converter, one input bit per clock; result held between conversions.
module sm_bin_to_bcd_8
  import sm_bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
)(
  input  logic               clock,
  input  logic               resetn,
  sm_bin_to_bcd_8_if.slave   bus
);
  localparam int          BW      = BCD_DIGIT_W * DIGITS;
  localparam int          CNT_W   = $clog2(WIDTH + 1);
  localparam logic [63:0] BCD_MAX = bcd_max(DIGITS);

  state_t                               state;
  logic [CNT_W-1:0]                     cnt;
  logic [WIDTH-1:0]                     shreg;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   scr;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   adj;
  logic [BW-1:0]                        adj_flat;
  logic [BW-1:0]                        scr_next;
  logic                                 ovf_cap;
  logic                                 in_ovf;
  logic                                 busy_r;
  logic                                 done_r;
  logic [BW-1:0]                        bcd_r;
  logic                                 ovf_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    sm_bcd_digit_adj u_adj (
      .din  (scr[g]),
      .dout (adj[g])
    );
  end

  assign adj_flat = adj;
  // Carry out of the top digit is dropped; only reachable when over-range.
  assign scr_next = {adj_flat[BW-2:0], shreg[WIDTH-1]};
  assign in_ovf   = 64'(bus.bin) > BCD_MAX;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      scr     <= '0;
      ovf_cap <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            shreg   <= bus.bin;
            scr     <= '0;
            cnt     <= '0;
            ovf_cap <= in_ovf;
            busy_r  <= 1'b1;
            state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          scr   <= scr_next;
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bcd_r  <= ovf_cap ? {DIGITS{4'h9}} : scr_next;
            ovf_r  <= ovf_cap;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd      = bcd_r;
  assign bus.overflow = ovf_r;

endmodule

// File: doc/sm_bin_to_bcd_8.md
Name: sm_bin_to_bcd_8

Overview:
Sequential binary-to-BCD converter using the double-dabble algorithm, one bit per clock. It sits directly upstream of the 8-digit hex display driver. Its packed BCD result drives that driver's 32-bit number input, so the display shows decimal instead of hex. The block uses a start/busy/done handshake and holds its result between conversions.

Parameters:
WIDTH, 32, bit width of the binary input; legal range 1..32.
DIGITS, 8, number of BCD digits produced; the bcd port is 4*DIGITS bits wide.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  request a conversion; sampled only when busy=0.
bin  input  WIDTH  unsigned binary operand; captured on the accepting edge only.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when a new result is latched on bcd.
bcd  output  4*DIGITS  packed BCD result; digit 0 (units) is in bits [3:0]. Held until the next completion.
overflow  output  1  set when the captured bin exceeded 10^DIGITS-1; updated together with bcd.

Behaviour:
- Reset (asynchronous, resetn low):
  - busy=0, done=0, bcd=0, overflow=0.
  - State IDLE, iteration counter 0.
  - Any conversion in flight is abandoned; no done pulse follows reset release.
- States:
  - IDLE: busy=0; done may be high for exactly one cycle after completion.
  - CONVERT: busy=1.
- Accept:
  - At a rising edge with state IDLE and start=1, the block captures bin into the shift register.
  - The scratch BCD register is cleared and the counter is set to 0.
  - The over-range compare (bin > 10^DIGITS-1) is registered.
  - State moves to CONVERT and busy becomes 1 from the next cycle.
- Iteration, each edge in CONVERT:
  - Every 4-bit scratch digit >= 5 gets +3 added.
  - Then {scratch, shift} shifts left by 1 and the counter increments.
  - Carries out of the top scratch digit are discarded; this only matters when over-range, and that result is replaced anyway.
- Completion:
  - On the edge performing iteration WIDTH (counter == WIDTH-1), bcd is loaded and done=1 for the following cycle.
  - bcd is loaded with the post-shift scratch value, or with all digits 9 (for example 32'h99999999) when the registered over-range flag is set.
  - On the same edge overflow is loaded with that flag, busy returns to 0 and state returns to IDLE.
- Latency: start-accept edge N gives done high in the cycle after edge N+WIDTH, i.e. WIDTH cycles (32 by default).
- Throughput and overlap:
  - start while busy=1 is ignored; there is no queueing.
  - start high in the done cycle is accepted, since the state is already IDLE. This gives back-to-back conversions with one idle cycle between them.
- Handshake: start held high continuously causes repeated conversions; done pulses every WIDTH+1 cycles.
- Input stability: bin may change freely after the accepting edge.
- Outputs: registered only, with no combinational path from inputs to outputs. bcd and overflow never change except on a completion edge or reset.
- Counter width: clog2(WIDTH+1); it must not wrap for WIDTH=32.

Decomposition:
- Shared package sm_bcd_pkg:
  - state encoding constants S_IDLE, S_CONVERT.
  - function bcd_max(DIGITS) returning 10^DIGITS-1, used for the over-range compare.
  - constant BCD_DIGIT_W = 4.
- One natural sub-module, sm_bcd_digit_adj:
  - combinational; 4-bit in, 4-bit out; adds 3 if the input is >= 5.
  - instantiated DIGITS times by generate inside the iteration datapath.

Test Plan:
- Reset, then start with bin=0 → done after exactly 32 cycles; bcd=32'h00000000, overflow=0; busy high for 32 cycles.
- bin=12345678 → bcd=32'h12345678; bin=99999999 → bcd=32'h99999999, overflow=0; bin=255 → bcd=32'h00000255.
- bin=100000000, then bin=32'hFFFFFFFF → bcd=32'h99999999, overflow=1 for both; a following bin=7 conversion gives bcd=32'h00000007, overflow=0.
- Start bin=42, pulse start with bin=999 at cycles 5 and 20 → both extra starts ignored; single done with bcd=32'h00000042.
- Start held high with bin alternating 1 and 2 each accept → done pulses 33 cycles apart; bcd alternates 32'h1 and 32'h2; bcd stable between pulses.
- Start bin=5555, assert resetn low at cycle 10 for 1 cycle → all outputs 0 immediately; no done pulse afterwards; a new start then completes normally with the correct value.
